reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Round-robin arbiter and sequencer for the motion system's internal 32-bit register bus. It shares the single register-file port between several requesters: the uP byte-handshake command decoder, the encoder snapshot logic and the PWM/status updaters. Each requester presents one read or write transaction. The arbiter grants one requester at a time, drives the bus strobes until the register slave acknowledges or a timeout expires, and returns the completion status and read data to the winner.

## Interface
Parameters:
- NOS_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, register address width.
- DATA_W, 32, register data width.
- TIMEOUT, 15, maximum ACCESS cycles to wait for bus_ack (1..255).

Ports:
- CLOCK_50  in  1  system clock; every flop is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NOS_REQ  per-requester transaction request, level.
- wr  in  NOS_REQ  per-requester direction; 1 = write, 0 = read.
- addr  in  NOS_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NOS_REQ*DATA_W  flattened write data, same packing as addr.
- gnt  out  NOS_REQ  one-hot grant.
- done  out  NOS_REQ  one-hot completion pulse, one cycle wide.
- rdata  out  DATA_W  read data returned to the winner; valid while done is high.
- err  out  1  timeout flag; valid while done is high.
- bus_addr  out  ADDR_W  register bus address.
- bus_wdata  out  DATA_W  register bus write data.
- bus_read, bus_write  out  1  bus strobes; never high together.
- bus_rdata  in  DATA_W  slave read data; sampled when bus_ack is high.
- bus_ack  in  1  slave acknowledge; ignored outside ACCESS.

## Operation
- States:
  - IDLE: no transaction in progress.
  - ACCESS: a transaction is on the bus.
  - DONE: completion cycle.
- All outputs are registered.
- IDLE with any req bit high:
  - Select the winner by round robin, searching from (last + 1) mod NOS_REQ upward with wrap-around.
  - Latch the winner's addr, wdata and wr into bus_addr, bus_wdata and the strobe.
  - Set gnt[w] = 1, clear the timeout counter and go to ACCESS.
- ACCESS:
  - Hold bus_read = ~wr_latched or bus_write = wr_latched.
  - The counter increments each cycle.
  - On bus_ack = 1: capture bus_rdata into rdata (reads only; writes return 0), set err = 0 and go to DONE.
  - If the counter reaches TIMEOUT without bus_ack: set rdata = 0, err = 1 and go to DONE.
  - If bus_ack and the timeout occur in the same cycle, bus_ack wins (err = 0).
- DONE:
  - Strobes are low, done[w] = 1 and gnt[w] stays 1.
  - Set last = w, then go to IDLE. On that transition gnt, done and err clear.
- Requesters hold req, wr, addr and wdata stable from req rising until done.
  - The arbiter latches the request at grant, so later changes are ignored.
  - If req is dropped during ACCESS, the transaction still completes and done still pulses.
  - If req is still high after done, it is treated as a new transaction and competes normally in round robin.
- Reset mid-operation:
  - All outputs clear immediately and asynchronously.
  - The state returns to IDLE and last resets to NOS_REQ-1, so requester 0 has first priority.
  - The bus transaction in progress is abandoned.
- Reset values: gnt = 0, done = 0, rdata = 0, err = 0, bus_addr = 0, bus_wdata = 0, bus_read = 0, bus_write = 0.

## Timing
- req rising, sampled at edge k:
  - gnt and the strobe go high after edge k.
  - A zero-wait slave holding bus_ack is sampled at edge k+1.
  - done is high for the cycle after k+1.
  - gnt drops after edge k+2.
- Minimum throughput: 3 cycles per transaction (IDLE, ACCESS, DONE).
- Slave wait states extend ACCESS one cycle each.
- Timeout path: ACCESS lasts exactly TIMEOUT cycles, then DONE.
- Fairness: with all requesters continuously requesting, each is granted once every NOS_REQ transactions. Maximum wait is (NOS_REQ-1) transactions.

## Test plan
- Reset, then a single write: req[1] = 1, wr[1] = 1, addr = 3, wdata = 42, zero-wait slave.
  - Required: bus_write high for 1 cycle with bus_addr = 3 and bus_wdata = 42; gnt = 4'b0010; done[1] pulses 2 cycles after the request; err = 0.
- Read with 3 wait states: req[0] reading addr = 5, slave returns 32'hDEADBEEF.
  - Required: bus_read high for 4 cycles; rdata = 32'hDEADBEEF while done[0] = 1.
- All four requesters held high for 8 transactions.
  - Required: grant order 0, 1, 2, 3, 0, 1, 2, 3; never more than one gnt bit set; strobes are never high together.
- Timeout: slave never acknowledges, TIMEOUT = 15.
  - Required: ACCESS lasts 15 cycles; done pulses with err = 1 and rdata = 0.
  - bus_ack arriving in the 15th ACCESS cycle instead yields err = 0.
- reset driven low during ACCESS.
  - Required: strobes, gnt and done drop asynchronously with no done pulse.
  - After reset, with req = 4'b1100, requester 2 is granted first.
- req[2] dropped during ACCESS.
  - Required: the transaction completes and done[2] pulses once; no further grant to requester 2.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// Register-bus arbiter interface.
// Bundles the requester-side handshake and the register-slave bus.
// The master modport is the arbiter's view. The slave modport is the
// view of the requesters and register slave that surround it.
interface reg_bus_arbiter_if #(
    parameter int NOS_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
);
    // Requester side
    logic [NOS_REQ-1:0]        req;
    logic [NOS_REQ-1:0]        wr;
    logic [NOS_REQ*ADDR_W-1:0] addr;
    logic [NOS_REQ*DATA_W-1:0] wdata;
    logic [NOS_REQ-1:0]        gnt;
    logic [NOS_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      err;

    // Register slave side
    logic [ADDR_W-1:0]         bus_addr;
    logic [DATA_W-1:0]         bus_wdata;
    logic                      bus_read;
    logic                      bus_write;
    logic [DATA_W-1:0]         bus_rdata;
    logic                      bus_ack;

    modport master (
        input  req, wr, addr, wdata, bus_rdata, bus_ack,
        output gnt, done, rdata, err, bus_addr, bus_wdata, bus_read, bus_write
    );

    modport slave (
        output req, wr, addr, wdata, bus_rdata, bus_ack,
        input  gnt, done, rdata, err, bus_addr, bus_wdata, bus_read, bus_write
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 32-bit register bus.
// The arbiter grants one requester at a time and latches its transaction.
// It drives the bus strobes until the slave acknowledges or the timeout
// expires. It then pulses done for one cycle with the status and read data.
module reg_bus_arbiter #(
    parameter int NOS_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    reg_bus_arbiter_if.master rb
);
    localparam int IDX_W = (NOS_REQ > 1) ? $clog2(NOS_REQ) : 1;
    localparam logic [IDX_W-1:0]   LAST_RST_C = IDX_W'(NOS_REQ - 1);
    localparam logic [7:0]         TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [NOS_REQ-1:0] ONE_C      = NOS_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    last_r;
    logic [IDX_W-1:0]    win_r;
    logic                wr_r;
    logic [7:0]          cnt_r;
    logic [NOS_REQ-1:0]  gnt_r;
    logic [NOS_REQ-1:0]  done_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                err_r;
    logic [ADDR_W-1:0]   bus_addr_r;
    logic [DATA_W-1:0]   bus_wdata_r;
    logic                bus_read_r;
    logic                bus_write_r;

    logic [IDX_W-1:0]    win_s;
    logic [7:0]          cnt_inc_s;

    // Round-robin search starting just after the last winner, with wrap-around.
    // Offsets are walked from farthest to nearest, so the nearest requester wins.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NOS_REQ-1:0] r,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        pick = last;
        for (int k = NOS_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NOS_REQ);
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Next winner and incremented timeout count, ahead of the state register.
    always_comb begin
        win_s     = rr_pick(rb.req, last_r);
        cnt_inc_s = cnt_r + 8'd1;
    end

    // Sequencer FSM: arbitrate, run the bus access, report completion.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            last_r      <= LAST_RST_C;
            win_r       <= '0;
            wr_r        <= 1'b0;
            cnt_r       <= 8'd0;
            gnt_r       <= '0;
            done_r      <= '0;
            rdata_r     <= '0;
            err_r       <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
            bus_read_r  <= 1'b0;
            bus_write_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|rb.req) begin
                        win_r       <= win_s;
                        wr_r        <= rb.wr[win_s];
                        gnt_r       <= ONE_C << win_s;
                        bus_addr_r  <= rb.addr[win_s*ADDR_W +: ADDR_W];
                        bus_wdata_r <= rb.wdata[win_s*DATA_W +: DATA_W];
                        bus_write_r <= rb.wr[win_s];
                        bus_read_r  <= ~rb.wr[win_s];
                        cnt_r       <= 8'd0;
                        state_r     <= ST_ACCESS;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // An acknowledge takes priority over a timeout in the same cycle.
                    if (rb.bus_ack) begin
                        rdata_r     <= wr_r ? '0 : rb.bus_rdata;
                        err_r       <= 1'b0;
                        done_r      <= gnt_r;
                        bus_read_r  <= 1'b0;
                        bus_write_r <= 1'b0;
                        state_r     <= ST_DONE;
                    end else if (cnt_inc_s == TIMEOUT_C) begin
                        rdata_r     <= '0;
                        err_r       <= 1'b1;
                        done_r      <= gnt_r;
                        bus_read_r  <= 1'b0;
                        bus_write_r <= 1'b0;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r       <= cnt_inc_s;
                        state_r     <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    last_r  <= win_r;
                    gnt_r   <= '0;
                    done_r  <= '0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r       <= '0;
                    done_r      <= '0;
                    err_r       <= 1'b0;
                    bus_read_r  <= 1'b0;
                    bus_write_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rb.gnt       = gnt_r;
    assign rb.done      = done_r;
    assign rb.rdata     = rdata_r;
    assign rb.err       = err_r;
    assign rb.bus_addr  = bus_addr_r;
    assign rb.bus_wdata = bus_wdata_r;
    assign rb.bus_read  = bus_read_r;
    assign rb.bus_write = bus_write_r;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter.
// Expected transactions are queued in predicted grant order. A negedge
// monitor checks each bus access and each done pulse against the queue.
module tb_reg_bus_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;

    reg_bus_arbiter_if #(.NOS_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bif ();

    reg_bus_arbiter #(.NOS_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .rb       (bif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   strobe_len = 0;

    // Slave model
    int          wait_states = 0;
    logic        no_ack = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    logic [7:0]  acc_cnt = 8'd0;

    assign bif.bus_ack   = (bif.bus_read | bif.bus_write) & ~no_ack & (acc_cnt == 8'(wait_states));
    assign bif.bus_rdata = slave_rdata;

    always @(posedge clk) begin
        acc_cnt <= (bif.bus_read | bif.bus_write) ? acc_cnt + 8'd1 : 8'd0;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic expect_txn(input int idx, input logic w, input logic [7:0] a,
                              input logic [31:0] d, input logic [31:0] rd,
                              input logic e, input int len);
        exp_t x;
        x.idx = idx; x.wr = w; x.addr = a; x.wdata = d; x.rdata = rd; x.err = e; x.len = len;
        sb.push_back(x);
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
        bif.wr[i]           = w;
        bif.addr[i*AW +: AW] = a;
        bif.wdata[i*DW +: DW] = d;
        bif.req[i]          = 1'b1;
    endtask

    // Wait until done_cnt reaches target; ends just after a negedge.
    task automatic run_until(input int target, input int max_cycles);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) begin
                hit = 1'b1;
                break;
            end
        end
        chk("wait_bound", 64'(hit), 64'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor: bus access contents, grant exclusivity, completion results.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            strobe_len = 0;
        end else begin
            chk("gnt_onehot", 64'($countones(bif.gnt) <= 1), 64'd1);
            if (bif.bus_read || bif.bus_write) begin
                chk("strobe_excl", 64'(bif.bus_read & bif.bus_write), 64'd0);
                if (strobe_len == 0 && sb.size() > 0) begin
                    chk("grant", 64'(bif.gnt), 64'd1 << sb[0].idx);
                    chk("bus_addr", 64'(bif.bus_addr), 64'(sb[0].addr));
                    chk("bus_write", 64'(bif.bus_write), 64'(sb[0].wr));
                    if (sb[0].wr) begin
                        chk("bus_wdata", 64'(bif.bus_wdata), 64'(sb[0].wdata));
                    end
                end
                strobe_len++;
            end
            if (bif.done != '0) begin
                if (sb.size() == 0) begin
                    chk("unexp_done", 64'(bif.done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done", 64'(bif.done), 64'd1 << e.idx);
                    chk("gnt_at_done", 64'(bif.gnt), 64'd1 << e.idx);
                    chk("rdata", 64'(bif.rdata), 64'(e.rdata));
                    chk("err", 64'(bif.err), 64'(e.err));
                    chk("strobe_len", 64'(strobe_len), 64'(e.len));
                end
                strobe_len = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gcount;
        bif.req   = '0;
        bif.wr    = '0;
        bif.addr  = '0;
        bif.wdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(bif.gnt), 64'd0);
        chk("rst_done", 64'(bif.done), 64'd0);
        chk("rst_rdata", 64'(bif.rdata), 64'd0);
        chk("rst_err", 64'(bif.err), 64'd0);
        chk("rst_bus_addr", 64'(bif.bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bif.bus_wdata), 64'd0);
        chk("rst_strobes", 64'({bif.bus_read, bif.bus_write}), 64'd0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Single zero-wait write from requester 1
        @(posedge clk);
        #1;
        set_req(1, 1'b1, 8'd3, 32'd42);
        expect_txn(1, 1'b1, 8'd3, 32'd42, 32'd0, 1'b0, 1);
        @(posedge clk);
        #1;
        chk("t1_gnt", 64'(bif.gnt), 64'b0010);
        chk("t1_write", 64'(bif.bus_write), 64'd1);
        @(posedge clk);
        #1;
        chk("t1_done", 64'(bif.done), 64'b0010);
        chk("t1_err", 64'(bif.err), 64'd0);
        bif.req[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_gnt_clear", 64'(bif.gnt), 64'd0);

        // Read with 3 wait states from requester 0
        wait_states = 3;
        slave_rdata = 32'hDEADBEEF;
        set_req(0, 1'b0, 8'd5, 32'd0);
        expect_txn(0, 1'b0, 8'd5, 32'd0, 32'hDEADBEEF, 1'b0, 4);
        run_until(done_cnt + 1, 20);
        bif.req[0] = 1'b0;

        // All four requesting: fair rotation starting at 0 after reset
        pulse_reset();
        wait_states = 0;
        slave_rdata = 32'hCAFE0000;
        for (int i = 0; i < NR; i++) begin
            set_req(i, (i % 2 == 0), 8'(8'h10 + i), 32'hA0000000 + 32'(i));
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                expect_txn(i, (i % 2 == 0), 8'(8'h10 + i), 32'hA0000000 + 32'(i),
                           (i % 2 == 0) ? 32'd0 : 32'hCAFE0000, 1'b0, 1);
            end
        end
        run_until(done_cnt + 8, 60);
        bif.req = '0;

        // Timeout: slave never acknowledges
        no_ack = 1'b1;
        set_req(3, 1'b0, 8'h20, 32'd0);
        expect_txn(3, 1'b0, 8'h20, 32'd0, 32'd0, 1'b1, TO);
        run_until(done_cnt + 1, 40);
        bif.req[3] = 1'b0;

        // Acknowledge in the final ACCESS cycle beats the timeout
        no_ack = 1'b0;
        wait_states = TO - 1;
        slave_rdata = 32'h5A5AA5A5;
        set_req(3, 1'b0, 8'h21, 32'd0);
        expect_txn(3, 1'b0, 8'h21, 32'd0, 32'h5A5AA5A5, 1'b0, TO);
        run_until(done_cnt + 1, 40);
        bif.req[3] = 1'b0;

        // Reset during ACCESS: asynchronous clear, no done pulse
        no_ack = 1'b1;
        wait_states = 0;
        set_req(1, 1'b1, 8'h30, 32'h77);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_strobes", 64'({bif.bus_read, bif.bus_write}), 64'd0);
        chk("t5_gnt", 64'(bif.gnt), 64'd0);
        chk("t5_done", 64'(bif.done), 64'd0);
        bif.req = '0;
        no_ack = 1'b0;
        slave_rdata = 32'h0BADF00D;
        @(negedge clk);
        #1 reset = 1'b1;
        set_req(2, 1'b0, 8'h40, 32'd0);
        set_req(3, 1'b0, 8'h41, 32'd0);
        expect_txn(2, 1'b0, 8'h40, 32'd0, 32'h0BADF00D, 1'b0, 1);
        expect_txn(3, 1'b0, 8'h41, 32'd0, 32'h0BADF00D, 1'b0, 1);
        run_until(done_cnt + 2, 20);
        bif.req = '0;

        // req[2] dropped during ACCESS: completes once, no regrant
        wait_states = 3;
        slave_rdata = 32'h11112222;
        set_req(2, 1'b0, 8'h50, 32'd0);
        expect_txn(2, 1'b0, 8'h50, 32'd0, 32'h11112222, 1'b0, 4);
        @(posedge clk);
        @(posedge clk);
        #1 bif.req[2] = 1'b0;
        run_until(done_cnt + 1, 20);
        @(negedge clk);
        gcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (bif.gnt != '0) gcount++;
        end
        chk("t6_no_regrant", 64'(gcount), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
